// File: rtl/multi_cycle_sequencer.sv
// Multi-cycle FETCH/DECODE/EXECUTE/MEMORY/WRITEBACK sequencer for the RV32I core.
// Decides when the decoder's choices take effect: gates IR, RF, DRAM and PC writes, and counts retired instructions.
module multi_cycle_sequencer #(
    parameter int TIMEOUT_CYCLES = 16,
    parameter int COUNT_WIDTH    = 32
) (
    input  logic                   Clock,
    input  logic                   ResetN,
    input  logic                   Start,
    input  logic [6:0]             OperationCode,
    input  logic                   FetchReady,
    input  logic                   DramReady,
    output logic                   FetchRequest,
    output logic                   InstructionRegisterWrite,
    output logic                   DramRequest,
    output logic                   DramWriteEnable,
    output logic                   RegisterFileWriteEnable,
    output logic                   PcWriteEnable,
    output logic                   Fault,
    output logic [COUNT_WIDTH-1:0] RetiredCount,
    output logic [2:0]             State
);

    // Handshake: a request is held high every cycle until the matching
    // ready is seen high in the same cycle; that cycle completes the transfer.

    typedef enum logic [2:0] {
        S_IDLE      = 3'd0,
        S_FETCH     = 3'd1,
        S_DECODE    = 3'd2,
        S_EXECUTE   = 3'd3,
        S_MEMORY    = 3'd4,
        S_WRITEBACK = 3'd5,
        S_FAULT     = 3'd7
    } state_t;

    localparam logic [6:0] OP_LOAD  = 7'b0000011;
    localparam logic [6:0] OP_STORE = 7'b0100011;
    localparam logic [6:0] OP_BR    = 7'b1100011;
    localparam logic [6:0] OP_R     = 7'b0110011;
    localparam logic [6:0] OP_I     = 7'b0010011;
    localparam logic [6:0] OP_LUI   = 7'b0110111;
    localparam logic [6:0] OP_JAL   = 7'b1101111;
    localparam logic [6:0] OP_JALR  = 7'b1100111;

    localparam int WAIT_W = (TIMEOUT_CYCLES < 1) ? 1 : $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [WAIT_W-1:0]      WAIT_LIMIT = WAIT_W'(TIMEOUT_CYCLES);
    localparam logic [WAIT_W-1:0]      WAIT_ONE   = WAIT_W'(1);
    localparam logic [COUNT_WIDTH-1:0] COUNT_ONE  = COUNT_WIDTH'(1);

    state_t                   state;
    logic [6:0]               opcode_q;
    logic [WAIT_W-1:0]        wait_cnt;
    logic [COUNT_WIDTH-1:0]   retired;
    logic                     fetch_req;
    logic                     dram_req;
    logic                     dram_we;
    logic                     rf_we;
    logic                     fault_q;

    logic is_mem;
    logic is_store;
    logic is_branch;
    logic is_alu;
    logic wd_expired;
    logic branch_retire;
    logic store_retire;
    logic pc_we;

    always_comb begin
        is_store  = (opcode_q == OP_STORE);
        is_mem    = (opcode_q == OP_LOAD) || is_store;
        is_branch = (opcode_q == OP_BR);
        is_alu    = (opcode_q == OP_R)   || (opcode_q == OP_I)   || (opcode_q == OP_LUI) ||
                    (opcode_q == OP_JAL) || (opcode_q == OP_JALR);
    end

    // A zero limit disables the watchdog; the counter then never moves.
    assign wd_expired    = (TIMEOUT_CYCLES != 0) && (wait_cnt == WAIT_LIMIT);
    assign branch_retire = (state == S_EXECUTE) && is_branch;
    assign store_retire  = (state == S_MEMORY) && is_store && DramReady;
    assign pc_we         = rf_we || branch_retire || store_retire;

    always_ff @(posedge Clock or negedge ResetN) begin
        if (!ResetN) begin
            state     <= S_IDLE;
            opcode_q  <= '0;
            wait_cnt  <= '0;
            retired   <= '0;
            fetch_req <= 1'b0;
            dram_req  <= 1'b0;
            dram_we   <= 1'b0;
            rf_we     <= 1'b0;
            fault_q   <= 1'b0;
        end else begin
            fetch_req <= 1'b0;
            dram_req  <= 1'b0;
            dram_we   <= 1'b0;
            rf_we     <= 1'b0;
            if (pc_we) begin
                retired <= retired + COUNT_ONE;
            end
            case (state)
                S_IDLE: begin
                    if (Start) begin
                        state     <= S_FETCH;
                        fetch_req <= 1'b1;
                        wait_cnt  <= '0;
                    end
                end
                S_FETCH: begin
                    if (FetchReady) begin
                        state <= S_DECODE;
                    end else if (wd_expired) begin
                        state   <= S_FAULT;
                        fault_q <= 1'b1;
                    end else begin
                        fetch_req <= 1'b1;
                        if (wait_cnt != WAIT_LIMIT) begin
                            wait_cnt <= wait_cnt + WAIT_ONE;
                        end
                    end
                end
                S_DECODE: begin
                    opcode_q <= OperationCode;
                    state    <= S_EXECUTE;
                end
                S_EXECUTE: begin
                    if (is_mem) begin
                        state    <= S_MEMORY;
                        dram_req <= 1'b1;
                        dram_we  <= is_store;
                        wait_cnt <= '0;
                    end else if (is_alu) begin
                        state <= S_WRITEBACK;
                        rf_we <= 1'b1;
                    end else if (is_branch) begin
                        state     <= S_FETCH;
                        fetch_req <= 1'b1;
                        wait_cnt  <= '0;
                    end else begin
                        state   <= S_FAULT;
                        fault_q <= 1'b1;
                    end
                end
                S_MEMORY: begin
                    if (DramReady) begin
                        if (is_store) begin
                            state     <= S_FETCH;
                            fetch_req <= 1'b1;
                            wait_cnt  <= '0;
                        end else begin
                            state <= S_WRITEBACK;
                            rf_we <= 1'b1;
                        end
                    end else if (wd_expired) begin
                        state   <= S_FAULT;
                        fault_q <= 1'b1;
                    end else begin
                        dram_req <= 1'b1;
                        dram_we  <= is_store;
                        if (wait_cnt != WAIT_LIMIT) begin
                            wait_cnt <= wait_cnt + WAIT_ONE;
                        end
                    end
                end
                S_WRITEBACK: begin
                    state     <= S_FETCH;
                    fetch_req <= 1'b1;
                    wait_cnt  <= '0;
                end
                S_FAULT: begin
                    state <= S_FAULT;
                end
                default: begin
                    state   <= S_FAULT;
                    fault_q <= 1'b1;
                end
            endcase
        end
    end

    assign FetchRequest             = fetch_req;
    assign InstructionRegisterWrite = (state == S_FETCH) && FetchReady;
    assign DramRequest              = dram_req;
    assign DramWriteEnable          = dram_we;
    assign RegisterFileWriteEnable  = rf_we;
    assign PcWriteEnable            = pc_we;
    assign Fault                    = fault_q;
    assign RetiredCount             = retired;
    assign State                    = state;

endmodule

// File: tb/tb_multi_cycle_sequencer.sv
// Directed bench for multi_cycle_sequencer: per-cycle state/strobe vectors with hand-computed expectations.
module tb_multi_cycle_sequencer;

    localparam int TO = 8;
    localparam int CW = 4;

    // Strobe vector bits: {Fault, FetchRequest, IRW, DramRequest, DWE, RFWE, PCWE}
    localparam logic [6:0] NONE = 7'd0;
    localparam logic [6:0] FR   = 7'd32;
    localparam logic [6:0] IRW  = 7'd16;
    localparam logic [6:0] DR   = 7'd8;
    localparam logic [6:0] DWE  = 7'd4;
    localparam logic [6:0] RFWE = 7'd2;
    localparam logic [6:0] PCWE = 7'd1;
    localparam logic [6:0] FLT  = 7'd64;

    localparam logic [6:0] OP_LOAD  = 7'b0000011;
    localparam logic [6:0] OP_STORE = 7'b0100011;
    localparam logic [6:0] OP_BR    = 7'b1100011;
    localparam logic [6:0] OP_R     = 7'b0110011;
    localparam logic [6:0] OP_BAD   = 7'b1111111;

    logic          clock;
    logic          reset_n;
    logic          start;
    logic [6:0]    opcode;
    logic          fetch_ready;
    logic          dram_ready;
    logic          fetch_request;
    logic          ir_write;
    logic          dram_request;
    logic          dram_we;
    logic          rf_we;
    logic          pc_we;
    logic          fault;
    logic [CW-1:0] retired;
    logic [2:0]    state;

    int n_vec = 0;
    int n_err = 0;
    logic [CW-1:0] exp_q[$];

    multi_cycle_sequencer #(.TIMEOUT_CYCLES(TO), .COUNT_WIDTH(CW)) dut (
        .Clock                    (clock),
        .ResetN                   (reset_n),
        .Start                    (start),
        .OperationCode            (opcode),
        .FetchReady               (fetch_ready),
        .DramReady                (dram_ready),
        .FetchRequest             (fetch_request),
        .InstructionRegisterWrite (ir_write),
        .DramRequest              (dram_request),
        .DramWriteEnable          (dram_we),
        .RegisterFileWriteEnable  (rf_we),
        .PcWriteEnable            (pc_we),
        .Fault                    (fault),
        .RetiredCount             (retired),
        .State                    (state)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, act, exp);
        end
    endtask

    // Inputs are set just after an edge; outputs are checked 1 time unit later, then one edge passes.
    task automatic cyc(input string tag, input logic [2:0] st, input logic [6:0] stb);
        #1;
        check({tag, "/state"}, {29'd0, state}, {29'd0, st});
        check({tag, "/strobes"},
              {25'd0, fault, fetch_request, ir_write, dram_request, dram_we, rf_we, pc_we},
              {25'd0, stb});
        @(posedge clock);
        #1;
    endtask

    task automatic do_reset();
        reset_n     = 1'b0;
        start       = 1'b0;
        fetch_ready = 1'b0;
        dram_ready  = 1'b0;
        opcode      = OP_R;
        repeat (2) @(posedge clock);
        #1;
        reset_n = 1'b1;
        #1;
        check("reset/state", {29'd0, state}, 32'd0);
        check("reset/count", {28'd0, retired}, 32'd0);
        check("reset/fault", {31'd0, fault}, 32'd0);
    endtask

    initial begin
        do_reset();

        // R-type, both readies tied high
        opcode = OP_R; fetch_ready = 1'b1; dram_ready = 1'b1; start = 1'b1;
        cyc("r_c0", 3'd0, NONE); start = 1'b0;
        cyc("r_c1", 3'd1, FR | IRW);
        cyc("r_c2", 3'd2, NONE);
        cyc("r_c3", 3'd3, NONE);
        cyc("r_c4", 3'd5, RFWE | PCWE);
        check("r_count", {28'd0, retired}, 32'd1);
        cyc("r_c5", 3'd1, FR | IRW);
        do_reset();

        // LOAD with DRAM ready three cycles late
        opcode = OP_LOAD; fetch_ready = 1'b1; dram_ready = 1'b0; start = 1'b1;
        cyc("ld_c0", 3'd0, NONE); start = 1'b0;
        cyc("ld_c1", 3'd1, FR | IRW);
        cyc("ld_c2", 3'd2, NONE);
        cyc("ld_c3", 3'd3, NONE);
        cyc("ld_c4", 3'd4, DR);
        cyc("ld_c5", 3'd4, DR);
        cyc("ld_c6", 3'd4, DR);
        dram_ready = 1'b1;
        cyc("ld_c7", 3'd4, DR);
        dram_ready = 1'b0;
        cyc("ld_c8", 3'd5, RFWE | PCWE);
        check("ld_count", {28'd0, retired}, 32'd1);
        cyc("ld_c9", 3'd1, FR | IRW);
        do_reset();

        // STORE then BEQ; opcode changes after DECODE must be ignored
        opcode = OP_STORE; fetch_ready = 1'b1; dram_ready = 1'b1; start = 1'b1;
        cyc("st_c0", 3'd0, NONE); start = 1'b0;
        cyc("st_c1", 3'd1, FR | IRW);
        cyc("st_c2", 3'd2, NONE);
        opcode = OP_R;
        cyc("st_c3", 3'd3, NONE);
        cyc("st_c4", 3'd4, DR | DWE | PCWE);
        opcode = OP_BR;
        cyc("br_c5", 3'd1, FR | IRW);
        cyc("br_c6", 3'd2, NONE);
        opcode = OP_BAD;
        cyc("br_c7", 3'd3, PCWE);
        check("stbr_count", {28'd0, retired}, 32'd2);
        cyc("br_c8", 3'd1, FR | IRW);
        do_reset();

        // Fetch watchdog: ready never arrives
        opcode = OP_R; fetch_ready = 1'b0; start = 1'b1;
        cyc("wd_c0", 3'd0, NONE); start = 1'b0;
        for (int i = 0; i <= TO; i++) cyc($sformatf("wd_wait%0d", i), 3'd1, FR);
        start = 1'b1; fetch_ready = 1'b1;
        cyc("wd_fault0", 3'd7, FLT);
        cyc("wd_fault1", 3'd7, FLT);
        start = 1'b0;
        do_reset();

        // Fetch watchdog: ready in the limit cycle wins
        opcode = OP_R; fetch_ready = 1'b0; start = 1'b1;
        cyc("wdok_c0", 3'd0, NONE); start = 1'b0;
        for (int i = 0; i < TO; i++) cyc($sformatf("wdok_wait%0d", i), 3'd1, FR);
        fetch_ready = 1'b1;
        cyc("wdok_limit", 3'd1, FR | IRW);
        cyc("wdok_decode", 3'd2, NONE);
        do_reset();

        // Illegal opcode
        opcode = OP_BAD; fetch_ready = 1'b1; dram_ready = 1'b1; start = 1'b1;
        cyc("bad_c0", 3'd0, NONE); start = 1'b0;
        cyc("bad_c1", 3'd1, FR | IRW);
        cyc("bad_c2", 3'd2, NONE);
        cyc("bad_c3", 3'd3, NONE);
        cyc("bad_c4", 3'd7, FLT);
        cyc("bad_c5", 3'd7, FLT);
        check("bad_count", {28'd0, retired}, 32'd0);
        do_reset();

        // Reset in the middle of a store's MEMORY phase (after one branch retired)
        opcode = OP_BR; fetch_ready = 1'b1; dram_ready = 1'b0; start = 1'b1;
        cyc("rm_c0", 3'd0, NONE); start = 1'b0;
        cyc("rm_c1", 3'd1, FR | IRW);
        cyc("rm_c2", 3'd2, NONE);
        cyc("rm_c3", 3'd3, PCWE);
        opcode = OP_STORE;
        cyc("rm_c4", 3'd1, FR | IRW);
        cyc("rm_c5", 3'd2, NONE);
        cyc("rm_c6", 3'd3, NONE);
        cyc("rm_c7", 3'd4, DR | DWE);
        check("rm_count_pre", {28'd0, retired}, 32'd1);
        reset_n = 1'b0;
        #1;
        check("rm_dreq", {31'd0, dram_request}, 32'd0);
        check("rm_dwe", {31'd0, dram_we}, 32'd0);
        check("rm_state", {29'd0, state}, 32'd0);
        check("rm_count", {28'd0, retired}, 32'd0);
        do_reset();

        // Sixteen branches wrap a 4-bit retired counter back to zero
        for (int i = 0; i < 16; i++) exp_q.push_back(CW'(i));
        exp_q.push_back(CW'(0));
        opcode = OP_BR; fetch_ready = 1'b1; start = 1'b1;
        cyc("wr_c0", 3'd0, NONE); start = 1'b0;
        for (int i = 0; i < 16; i++) begin
            cyc($sformatf("wr%0d_f", i), 3'd1, FR | IRW);
            check($sformatf("wr%0d_count", i), {28'd0, retired}, {28'd0, exp_q.pop_front()});
            cyc($sformatf("wr%0d_d", i), 3'd2, NONE);
            cyc($sformatf("wr%0d_e", i), 3'd3, PCWE);
        end
        check("wr_final", {28'd0, retired}, {28'd0, exp_q.pop_front()});

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
